multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32I-subset core; replaces the single-cycle decode path.
- Fetches each instruction over a shared instruction/data memory port with a ready handshake and latches its own copy of opcode/funct fields.
- Steps the datapath through FETCH/DECODE/EXEC/MEM/WB, driving the same control set as the single-cycle decoder (ALUControl, RegWrite, MemWrite, Branch, MemToReg, ALUScr) plus PC/IR/memory sequencing.
- Counts retired instructions and traps on illegal encodings or memory timeout.

Parameters:
- BITS, 32, instruction/data word width.
- MEM_TIMEOUT, 16, max wait cycles per memory handshake before trap; must be >=1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- instr_rdata  input  BITS  memory read data; valid when mem_ready=1 in FETCH.
- mem_ready  input  1  memory completes the current request this cycle.
- zero  input  1  ALU zero flag, valid in BRANCH.
- mem_req  output  1  memory request strobe.
- adr_src  output  1  0=PC address, 1=ALU-result address.
- ir_write  output  1  datapath IR/OldPC load enable.
- pc_write  output  1  PC load enable.
- pc_src  output  1  0=PC+4, 1=branch target (OldPC+imm).
- alu_control  output  2  00 add, 01 sub, 10 and, 11 or.
- alu_src  output  1  0=rs2, 1=immediate.
- reg_write  output  1  register file write enable.
- mem_write  output  1  memory write (with mem_req).
- mem_to_reg  output  1  writeback select: 1=memory data.
- branch  output  1  high in BRANCH state.
- halted  output  1  high in TRAP.
- trap_cause  output  2  00 none, 01 illegal instruction, 10 memory timeout.
- retired  output  32  instructions completed, wraps at 2^32.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP. Registered state; outputs are decoded from state, latched fields, mem_ready and zero.
- Reset (rst_n=0 at edge): state=FETCH; retired=0; trap_cause=00; wait counter=0; latched fields=0. During reset all outputs are 0 and halted=0, including any reset asserted mid-instruction or in TRAP.
- FETCH:
  - mem_req=1, adr_src=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0; latch opcode=instr_rdata[6:2], funct3=[14:12], f7b=[30]; go to DECODE.
- DECODE (1 cycle), by opcode:
  - 01100 R-type → EXEC.
  - 00100 I-ALU → EXEC.
  - 00000 load (funct3=010) → EXEC.
  - 01000 store (funct3=010) → EXEC.
  - 11000 branch (funct3 000 beq / 001 bne) → BRANCH.
  - Any other opcode, or unlisted funct3, → TRAP with cause 01.
- ALU op decode:
  - funct3 000: add, except R-type with f7b=1 = sub.
  - funct3 111: and.
  - funct3 110: or.
  - Other funct3 for R-type or I-ALU → illegal.
- EXEC (1 cycle):
  - alu_src=1 for I-ALU/load/store, 0 for R-type; alu_control from decode; load/store force add.
  - Next state: R-type/I-ALU → WB; load/store → MEM.
- MEM:
  - mem_req=1, adr_src=1; mem_write=1 for stores.
  - On mem_ready: load → WB; store → FETCH and retired+1.
- WB (1 cycle): reg_write=1, mem_to_reg=1 for load else 0; → FETCH, retired+1.
- BRANCH (1 cycle):
  - branch=1, alu_src=0, alu_control=01.
  - Taken when (beq & zero) | (bne & !zero); if taken, pc_write=1 and pc_src=1.
  - → FETCH, retired+1.
- Cycle counts at zero-wait memory: R-type/I-ALU 4, load 5, store 4, branch 3.
- Wait counter:
  - Increments each cycle mem_req=1 and mem_ready=0; clears on handshake or state change.
  - When it reaches MEM_TIMEOUT with mem_ready still 0 → TRAP, cause 10.
  - A mem_ready=1 in the cycle the count equals MEM_TIMEOUT-1 completes normally.
- TRAP: absorbing until reset; halted=1; all strobes 0; trap_cause and retired hold.
- mem_ready while mem_req=0 is ignored.
- retired wraps 0xFFFFFFFF→0 without side effects.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release → state FETCH, mem_req=1, retired=0, halted=0, trap_cause=00.
- add x3,x1,x2 (0x002081B3), mem_ready=1 → ir_write/pc_write in cycle 0; EXEC alu_control=00, alu_src=0; reg_write in cycle 3; retired=1 after 4 cycles. sub (0x402081B3) → alu_control=01.
- lw (0x0000A183) with 2 MEM wait cycles → mem_req & adr_src=1 for 3 cycles; WB has mem_to_reg=1, reg_write=1; total 7 cycles. sw (0x0030A023) → mem_write=1 in MEM, no reg_write.
- beq (0x00208463): zero=1 → pc_write=1, pc_src=1 in BRANCH. zero=0 → pc_write=0. bne inverts both cases. Each takes 3 cycles.
- Illegal opcode 0x0000007F → TRAP after DECODE, trap_cause=01, halted=1, no strobes for 10 cycles. rst_n=0 recovers to FETCH.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 → TRAP at cycle 16, cause 10. mem_ready=1 at cycle 15 → normal DECODE.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle for the multi-cycle RV32I-subset core.
// The master side is the controller; the slave side is the datapath and memory.
interface multicycle_controller_if #(
  parameter int unsigned BITS = 32
);
  logic [BITS-1:0] instr_rdata;
  logic            mem_ready;
  logic            zero;
  logic            mem_req;
  logic            adr_src;
  logic            ir_write;
  logic            pc_write;
  logic            pc_src;
  logic [1:0]      alu_control;
  logic            alu_src;
  logic            reg_write;
  logic            mem_write;
  logic            mem_to_reg;
  logic            branch;
  logic            halted;
  logic [1:0]      trap_cause;
  logic [31:0]     retired;

  modport master (
    input  instr_rdata, mem_ready, zero,
    output mem_req, adr_src, ir_write, pc_write, pc_src, alu_control, alu_src,
           reg_write, mem_write, mem_to_reg, branch, halted, trap_cause, retired
  );

  modport slave (
    output instr_rdata, mem_ready, zero,
    input  mem_req, adr_src, ir_write, pc_write, pc_src, alu_control, alu_src,
           reg_write, mem_write, mem_to_reg, branch, halted, trap_cause, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB/BRANCH control FSM with retire counter
// and traps for illegal encodings and memory handshake timeout.
module multicycle_controller #(
  parameter int unsigned BITS        = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [4:0] OP_R   = 5'b01100;
  localparam logic [4:0] OP_I   = 5'b00100;
  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_ST  = 5'b01000;
  localparam logic [4:0] OP_BR  = 5'b11000;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_TRAP
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    opcode_q, opcode_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          f7b_q, f7b_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   retired_q, retired_d;
  logic [1:0]    cause_q, cause_d;

  logic       is_r, is_i, is_ld, is_st, is_br, alu_legal, legal, taken, timeout;
  logic [1:0] alu_op;

  // Only the opcode/funct fields matter; the rest of the word is consumed here.
  logic unused_rdata;
  assign unused_rdata = ^bus.instr_rdata[BITS-1:0];

  // Instruction class and ALU op decode from the latched fields
  always_comb begin
    is_r  = (opcode_q == OP_R);
    is_i  = (opcode_q == OP_I);
    is_ld = (opcode_q == OP_LD) && (funct3_q == 3'b010);
    is_st = (opcode_q == OP_ST) && (funct3_q == 3'b010);
    is_br = (opcode_q == OP_BR) && (funct3_q[2:1] == 2'b00);
    alu_legal = 1'b1;
    alu_op    = 2'b00;
    case (funct3_q)
      3'b000:  alu_op = (is_r && f7b_q) ? 2'b01 : 2'b00;
      3'b111:  alu_op = 2'b10;
      3'b110:  alu_op = 2'b11;
      default: alu_legal = 1'b0;
    endcase
    legal = ((is_r || is_i) && alu_legal) || is_ld || is_st || is_br;
    taken = bus.zero ^ funct3_q[0];
  end

  // Next state, bookkeeping and control outputs
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    f7b_d     = f7b_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    wait_d    = '0;
    timeout   = 1'b0;

    bus.mem_req     = 1'b0;
    bus.adr_src     = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 1'b0;
    bus.alu_control = 2'b00;
    bus.alu_src     = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.branch      = 1'b0;
    bus.halted      = 1'b0;
    bus.trap_cause  = cause_q;
    bus.retired     = retired_q;

    // Wait count only advances while a request is outstanding and unanswered
    if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready) begin
      if (wait_q == WAIT_LAST) timeout = 1'b1;
      else                     wait_d  = wait_q + CW'(1);
    end

    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          opcode_d = bus.instr_rdata[6:2];
          funct3_d = bus.instr_rdata[14:12];
          f7b_d    = bus.instr_rdata[30];
          state_d  = S_DECODE;
        end else if (timeout) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          cause_d = 2'b01;
          state_d = S_TRAP;
        end else begin
          state_d = is_br ? S_BRANCH : S_EXEC;
        end
      end
      S_EXEC: begin
        bus.alu_src     = !is_r;
        bus.alu_control = (is_ld || is_st) ? 2'b00 : alu_op;
        state_d         = (is_ld || is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.mem_req   = 1'b1;
        bus.adr_src   = 1'b1;
        bus.mem_write = is_st;
        if (bus.mem_ready) begin
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
        end else if (timeout) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = is_ld;
        retired_d      = retired_q + 32'd1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        bus.branch      = 1'b1;
        bus.alu_control = 2'b01;
        bus.pc_write    = taken;
        bus.pc_src      = taken;
        retired_d       = retired_q + 32'd1;
        state_d         = S_FETCH;
      end
      default: begin
        bus.halted = 1'b1;
        state_d    = S_TRAP;
      end
    endcase

    // Reset blanks every output immediately, not just after the edge
    if (!rst_n) begin
      bus.mem_req     = 1'b0;
      bus.adr_src     = 1'b0;
      bus.ir_write    = 1'b0;
      bus.pc_write    = 1'b0;
      bus.pc_src      = 1'b0;
      bus.alu_control = 2'b00;
      bus.alu_src     = 1'b0;
      bus.reg_write   = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_to_reg  = 1'b0;
      bus.branch      = 1'b0;
      bus.halted      = 1'b0;
      bus.trap_cause  = 2'b00;
      bus.retired     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      funct3_q  <= '0;
      f7b_q     <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      f7b_q     <= f7b_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors
// are queued with the stimulus and popped at each sample point.
module tb_multicycle_controller;
  localparam int unsigned BITS = 32;
  localparam int unsigned TO   = 16;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_ANDI = 32'h0010F093;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_SLL  = 32'h002091B3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.BITS(BITS)) bus ();
  multicycle_controller #(.BITS(BITS), .MEM_TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [14:0] exp_q[$];
  logic [31:0] exp_retired = 32'd0;

  // {mem_req, adr_src, ir_write, pc_write, pc_src, alu_control, alu_src,
  //  reg_write, mem_write, mem_to_reg, branch, halted, trap_cause}
  function automatic logic [14:0] cv(input logic mreq, adr, irw, pcw, pcs,
                                     input logic [1:0] aluc, input logic alus,
                                     rw, mw, m2r, br, hlt, input logic [1:0] tc);
    return {mreq, adr, irw, pcw, pcs, aluc, alus, rw, mw, m2r, br, hlt, tc};
  endfunction

  function automatic logic [14:0] f_rdy();             return cv(1,0,1,1,0,2'b00,0,0,0,0,0,0,2'b00); endfunction
  function automatic logic [14:0] f_wait();            return cv(1,0,0,0,0,2'b00,0,0,0,0,0,0,2'b00); endfunction
  function automatic logic [14:0] idle();              return 15'd0; endfunction
  function automatic logic [14:0] ex(input logic [1:0] a, input logic s); return cv(0,0,0,0,0,a,s,0,0,0,0,0,2'b00); endfunction
  function automatic logic [14:0] wb(input logic m2r); return cv(0,0,0,0,0,2'b00,0,1,0,m2r,0,0,2'b00); endfunction
  function automatic logic [14:0] mem(input logic mw); return cv(1,1,0,0,0,2'b00,0,0,mw,0,0,0,2'b00); endfunction
  function automatic logic [14:0] br(input logic t);   return cv(0,0,0,t,t,2'b01,0,0,0,0,1,0,2'b00); endfunction
  function automatic logic [14:0] trp(input logic [1:0] c); return cv(0,0,0,0,0,2'b00,0,0,0,0,0,1,c); endfunction

  task automatic push(input logic [14:0] e);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance past the next rise
  task automatic tick(input logic rn, input logic rdy, input logic [31:0] rd,
                      input logic z, input string tag);
    logic [14:0] o;
    logic [14:0] e;
    rst_n           = rn;
    bus.mem_ready   = rdy;
    bus.instr_rdata = rd;
    bus.zero        = z;
    @(negedge clk);
    o = {bus.mem_req, bus.adr_src, bus.ir_write, bus.pc_write, bus.pc_src,
         bus.alu_control, bus.alu_src, bus.reg_write, bus.mem_write,
         bus.mem_to_reg, bus.branch, bus.halted, bus.trap_cause};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_ret(input string tag);
    vectors++;
    assert (bus.retired === exp_retired) else begin
      miscompares++;
      $error("FAIL %s retired observed=%0d expected=%0d", tag, bus.retired, exp_retired);
    end
  endtask

  initial begin
    bus.mem_ready   = 1'b0;
    bus.instr_rdata = '0;
    bus.zero        = 1'b0;
    @(posedge clk);
    #1;

    // Reset for two cycles: every output low
    push(idle()); tick(0, 1, I_ADD, 1, "reset0");
    push(idle()); tick(0, 1, I_ADD, 1, "reset1");
    check_ret("reset_retired");

    // add: fetch, decode, exec(add, rs2), writeback
    push(f_rdy()); tick(1, 1, I_ADD, 0, "add_fetch");
    push(idle());  tick(1, 0, '0, 0, "add_decode");
    push(ex(2'b00, 0)); tick(1, 0, '0, 0, "add_exec");
    push(wb(0));   tick(1, 0, '0, 0, "add_wb");
    exp_retired++; check_ret("add_retired");

    // sub selects alu_control 01
    push(f_rdy()); tick(1, 1, I_SUB, 0, "sub_fetch");
    push(idle());  tick(1, 0, '0, 0, "sub_decode");
    push(ex(2'b01, 0)); tick(1, 0, '0, 0, "sub_exec");
    push(wb(0));   tick(1, 0, '0, 0, "sub_wb");
    exp_retired++; check_ret("sub_retired");

    // addi and andi use the immediate operand
    push(f_rdy()); tick(1, 1, I_ADDI, 0, "addi_fetch");
    push(idle());  tick(1, 0, '0, 0, "addi_decode");
    push(ex(2'b00, 1)); tick(1, 0, '0, 0, "addi_exec");
    push(wb(0));   tick(1, 0, '0, 0, "addi_wb");
    push(f_rdy()); tick(1, 1, I_ANDI, 0, "andi_fetch");
    push(idle());  tick(1, 0, '0, 0, "andi_decode");
    push(ex(2'b10, 1)); tick(1, 0, '0, 0, "andi_exec");
    push(wb(0));   tick(1, 0, '0, 0, "andi_wb");
    exp_retired += 2; check_ret("ialu_retired");

    // lw with two MEM wait cycles; mem_ready outside requests is ignored
    push(f_rdy()); tick(1, 1, I_LW, 0, "lw_fetch");
    push(idle());  tick(1, 1, '0, 0, "lw_decode");
    push(ex(2'b00, 1)); tick(1, 1, '0, 0, "lw_exec");
    push(mem(0));  tick(1, 0, '0, 0, "lw_mem_w0");
    push(mem(0));  tick(1, 0, '0, 0, "lw_mem_w1");
    push(mem(0));  tick(1, 1, '0, 0, "lw_mem_rdy");
    push(wb(1));   tick(1, 0, '0, 0, "lw_wb");
    exp_retired++; check_ret("lw_retired");

    // sw: mem_write in MEM, retires straight back to FETCH
    push(f_rdy()); tick(1, 1, I_SW, 0, "sw_fetch");
    push(idle());  tick(1, 0, '0, 0, "sw_decode");
    push(ex(2'b00, 1)); tick(1, 0, '0, 0, "sw_exec");
    push(mem(1));  tick(1, 1, '0, 0, "sw_mem");
    exp_retired++; check_ret("sw_retired");
    push(f_wait()); tick(1, 0, '0, 0, "sw_back_to_fetch");

    // beq/bne, both zero polarities
    push(f_rdy()); tick(1, 1, I_BEQ, 0, "beq1_fetch");
    push(idle());  tick(1, 0, '0, 0, "beq1_decode");
    push(br(1));   tick(1, 0, '0, 1, "beq_taken");
    push(f_rdy()); tick(1, 1, I_BEQ, 0, "beq0_fetch");
    push(idle());  tick(1, 0, '0, 0, "beq0_decode");
    push(br(0));   tick(1, 0, '0, 0, "beq_not_taken");
    push(f_rdy()); tick(1, 1, I_BNE, 0, "bne1_fetch");
    push(idle());  tick(1, 0, '0, 0, "bne1_decode");
    push(br(0));   tick(1, 0, '0, 1, "bne_not_taken");
    push(f_rdy()); tick(1, 1, I_BNE, 0, "bne0_fetch");
    push(idle());  tick(1, 0, '0, 0, "bne0_decode");
    push(br(1));   tick(1, 0, '0, 0, "bne_taken");
    exp_retired += 4; check_ret("branch_retired");

    // Illegal opcode: trap is absorbing, retired holds
    push(f_rdy()); tick(1, 1, I_ILL, 0, "ill_fetch");
    push(idle());  tick(1, 1, '0, 0, "ill_decode");
    for (int i = 0; i < 10; i++) begin
      push(trp(2'b01));
      tick(1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), "ill_trap");
    end
    check_ret("trap_retired_hold");

    // Reset out of TRAP
    push(idle());   tick(0, 0, '0, 0, "trap_reset");
    exp_retired = 32'd0; check_ret("trap_reset_retired");

    // FETCH timeout: 16 unanswered cycles then TRAP cause 10
    for (int i = 0; i < TO; i++) begin
      push(f_wait()); tick(1, 0, '0, 0, "to_wait");
    end
    push(trp(2'b10)); tick(1, 0, '0, 0, "to_trap");
    push(idle());     tick(0, 0, '0, 0, "to_reset");

    // mem_ready on the last allowed cycle completes normally
    for (int i = 0; i < TO - 1; i++) begin
      push(f_wait()); tick(1, 0, '0, 0, "late_wait");
    end
    push(f_rdy());  tick(1, 1, I_ADD, 0, "late_fetch");
    push(idle());   tick(1, 0, '0, 0, "late_decode");
    push(ex(2'b00, 0)); tick(1, 0, '0, 0, "late_exec");
    push(wb(0));    tick(1, 0, '0, 0, "late_wb");
    exp_retired++; check_ret("late_retired");

    // R-type with unsupported funct3 traps as illegal
    push(f_rdy());  tick(1, 1, I_SLL, 0, "sll_fetch");
    push(idle());   tick(1, 0, '0, 0, "sll_decode");
    push(trp(2'b01)); tick(1, 0, '0, 0, "sll_trap");
    check_ret("sll_retired_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
